fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer_pkg.sv | 48 ++++
 rtl/fetch_grp_compact.sv | 32 +++
 rtl/fetch_buffer.sv | 124 ++++++++++++
 tb/tb_fetch_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-path types and instruction-cache geometry.
// fetch_buffer honours the optional macro FETCH_BUF_BYPASS_EN (same-cycle bypass when empty).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ICACHE_WORD_NUM
`define ICACHE_WORD_NUM 8
`endif
`ifndef ICACHE_BLOCK_WIDTH
`define ICACHE_BLOCK_WIDTH 256
`endif
`ifndef ICACHE_OFFSET_WIDTH
`define ICACHE_OFFSET_WIDTH 5
`endif

package fetch_buffer_pkg;

  localparam int FB_XLEN     = `XLEN;
  localparam int FB_WORD_NUM = `ICACHE_WORD_NUM;
  localparam int FB_BLOCK_W  = `ICACHE_BLOCK_WIDTH;
  localparam int FB_OFF_W    = `ICACHE_OFFSET_WIDTH;
  localparam int FB_IDX_W    = $clog2(FB_WORD_NUM);
  localparam int FB_PCNT_W   = FB_IDX_W + 1;
  localparam int FB_DISP_W   = 3;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } MEM_SIZE;

  typedef struct packed {
    logic [31:0]        inst;
    logic [FB_XLEN-1:0] pc;
  } fb_entry_t;

  function automatic int fb_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_grp_compact.sv
// Packs the valid words of a fetch group to the low entries, attaching each word's PC,
// and reports how many words are valid.
module fetch_grp_compact
  import fetch_buffer_pkg::*;
(
  input  logic [FB_BLOCK_W-1:0]          fetch_grp,
  input  logic [FB_WORD_NUM-1:0]         mask,
  input  logic [FB_XLEN-1:0]             fetch_grp_pc,
  output fb_entry_t [FB_WORD_NUM-1:0]    entries,
  output logic [FB_PCNT_W-1:0]           push_cnt
);

  logic [FB_XLEN-1:0] base_pc;

  // The incoming PC may point anywhere inside the block; word PCs are relative to its start.
  assign base_pc = fetch_grp_pc & ~FB_XLEN'((1 << FB_OFF_W) - 1);

  always_comb begin : compact
    logic [FB_PCNT_W-1:0] k;
    k = '0;
    entries = '0;
    for (int i = 0; i < FB_WORD_NUM; i++) begin
      if (mask[i]) begin
        entries[k[FB_IDX_W-1:0]].inst = fetch_grp[32*i +: 32];
        entries[k[FB_IDX_W-1:0]].pc   = base_pc + FB_XLEN'(4 * i);
        k = k + 1'b1;
      end
    end
    push_cnt = k;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch queue between the I-cache and decode; slot 0 is always the oldest entry.
// Define FETCH_BUF_BYPASS_EN to forward an incoming group straight to decode when the queue is empty.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DISP_W = FB_DISP_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FB_BLOCK_W-1:0]      fetch_grp,
  input  logic [FB_WORD_NUM-1:0]     fetch_grp_valid,
  input  logic [FB_XLEN-1:0]         fetch_grp_pc,
  output logic                       fetch_grp_ready,
  output logic [DISP_W*32-1:0]       inst_out,
  output logic [DISP_W*FB_XLEN-1:0]  inst_pc_out,
  output logic [DISP_W-1:0]          inst_valid,
  input  logic                       dec_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = $bits(fb_entry_t);

  fb_entry_t                    mem [DEPTH];
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  fb_entry_t [FB_WORD_NUM-1:0]  grp_entries;
  fb_entry_t [FB_WORD_NUM-1:0]  wr_entries;
  logic [FB_PCNT_W-1:0]         grp_cnt;
  logic                         push;
  logic                         bypass;
  logic                         empty;
  logic                         full;
  logic [CNT_W-1:0]             push_n;
  logic [CNT_W-1:0]             pop_n;
  logic [CNT_W-1:0]             mem_pop;
  logic [CNT_W-1:0]             wr_off;
  logic [CNT_W-1:0]             wr_cnt;
  logic [CNT_W-1:0]             avail;
  logic [CNT_W-1:0]             n_slots;

  fetch_grp_compact u_compact (
    .fetch_grp    (fetch_grp),
    .mask         (fetch_grp_valid),
    .fetch_grp_pc (fetch_grp_pc),
    .entries      (grp_entries),
    .push_cnt     (grp_cnt)
  );

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Handshakes: a group is taken on any edge where fetch_grp_valid != 0 and fetch_grp_ready
  // is high (ready only promises room for a whole block); decode takes every valid slot on
  // any edge where dec_ready is high. Flush and reset win over both.
  assign fetch_grp_ready = rst | (~full & (CNT_W'(DEPTH) - count >= CNT_W'(FB_WORD_NUM)) & ~flush);
  assign push            = (|fetch_grp_valid) & fetch_grp_ready & ~rst;
  assign push_n          = push ? CNT_W'(grp_cnt) : '0;

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = push & empty;
`else
  assign bypass = 1'b0;
`endif

  assign avail   = bypass ? push_n : count;
  assign n_slots = CNT_W'(fb_min(int'(avail), DISP_W));
  assign pop_n   = (dec_ready & ~flush & ~rst) ? n_slots : '0;
  assign mem_pop = bypass ? '0 : pop_n;

  // Words consumed by decode in a bypass cycle never enter the queue.
  assign wr_off     = bypass ? pop_n : '0;
  assign wr_cnt     = push_n - wr_off;
  assign wr_entries = grp_entries >> (ENT_W * int'(wr_off));

  always_comb begin
    inst_valid  = '0;
    inst_out    = '0;
    inst_pc_out = '0;
    for (int k = 0; k < DISP_W; k++) begin
      if (!flush && !rst && (CNT_W'(k) < n_slots)) begin
        inst_valid[k] = 1'b1;
        if (bypass) begin
          inst_out[32*k +: 32]           = grp_entries[FB_IDX_W'(k)].inst;
          inst_pc_out[FB_XLEN*k +: FB_XLEN] = grp_entries[FB_IDX_W'(k)].pc;
        end else begin
          inst_out[32*k +: 32]           = mem[head + PTR_W'(k)].inst;
          inst_pc_out[FB_XLEN*k +: FB_XLEN] = mem[head + PTR_W'(k)].pc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(mem_pop);
      tail  <= tail + PTR_W'(wr_cnt);
      count <= count + push_n - pop_n;
    end
  end

  // Storage is not reset: an entry is only ever read after it has been written behind tail.
  always_ff @(posedge clk) begin
    for (int j = 0; j < FB_WORD_NUM; j++) begin
      if (CNT_W'(j) < wr_cnt) begin
        mem[tail + PTR_W'(j)] <= wr_entries[FB_IDX_W'(j)];
      end
    end
  end

  no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(full && push));

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized self-checking bench for fetch_buffer against a queue-of-instructions model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DISP_W = FB_DISP_W;
  localparam int WN     = FB_WORD_NUM;
  localparam int XL     = FB_XLEN;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [FB_BLOCK_W-1:0]  fetch_grp = '0;
  logic [WN-1:0]          fetch_grp_valid = '0;
  logic [XL-1:0]          fetch_grp_pc = '0;
  logic                   fetch_grp_ready;
  logic [DISP_W*32-1:0]   inst_out;
  logic [DISP_W*XL-1:0]   inst_pc_out;
  logic [DISP_W-1:0]      inst_valid;
  logic                   dec_ready = 1'b0;
  logic                   flush = 1'b0;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  // each entry is {inst, pc}, oldest first
  logic [63:0] exp_q[$];

  fetch_buffer #(.DEPTH(DEPTH), .DISP_W(DISP_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_grp       (fetch_grp),
    .fetch_grp_valid (fetch_grp_valid),
    .fetch_grp_pc    (fetch_grp_pc),
    .fetch_grp_ready (fetch_grp_ready),
    .inst_out        (inst_out),
    .inst_pc_out     (inst_pc_out),
    .inst_valid      (inst_valid),
    .dec_ready       (dec_ready),
    .flush           (flush),
    .count           (count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance model and DUT.
  task automatic step(input logic [WN-1:0] mask, input logic [XL-1:0] pc,
                      input logic dec, input logic fl);
    logic [63:0] inc[$];
    logic [63:0] vis[$];
    logic [63:0] want;
    logic [XL-1:0] base;
    int n, ns, pops;
    logic rdy, pushing, byp;
    for (int i = 0; i < WN; i++) fetch_grp[32*i +: 32] = $urandom();
    fetch_grp_valid = mask;
    fetch_grp_pc    = pc;
    dec_ready       = dec;
    flush           = fl;
    #2;
    n       = exp_q.size();
    rdy     = (DEPTH - n >= WN) && !fl;
    pushing = (mask != 0) && rdy;
    base    = pc & ~XL'(WN * 4 - 1);
    for (int i = 0; i < WN; i++)
      if (mask[i]) inc.push_back({fetch_grp[32*i +: 32], base + XL'(4 * i)});
    byp = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
    byp = pushing && (n == 0);
`endif
    if (byp) vis = inc;
    else vis = exp_q;
    ns = fl ? 0 : ((vis.size() < DISP_W) ? vis.size() : DISP_W);
    check_val("count", 64'(count), 64'(n));
    check_val("ready", 64'(fetch_grp_ready), 64'(rdy));
    check_val("valid", 64'(inst_valid), 64'((1 << ns) - 1));
    for (int k = 0; k < DISP_W; k++) begin
      want = (k < ns) ? vis[k] : 64'd0;
      check_val($sformatf("inst%0d", k), 64'(inst_out[32*k +: 32]), 64'(want[63:32]));
      check_val($sformatf("pc%0d", k), 64'(inst_pc_out[XL*k +: XL]), 64'(want[31:0]));
    end
    if (fl) begin
      exp_q.delete();
    end else begin
      pops = dec ? ns : 0;
      if (byp) begin
        for (int p = 0; p < pops; p++) void'(inc.pop_front());
        exp_q = inc;
      end else begin
        for (int p = 0; p < pops; p++) void'(exp_q.pop_front());
        if (pushing) foreach (inc[i]) exp_q.push_back(inc[i]);
      end
    end
    @(posedge clk);
    #1;
    fetch_grp_valid = '0;
    dec_ready       = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic reset_check(input int cycles);
    rst = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < WN; i++) fetch_grp[32*i +: 32] = $urandom();
      fetch_grp_valid = '1;
      fetch_grp_pc    = $urandom();
      dec_ready       = 1'b1;
      flush           = 1'b0;
      #2;
      check_val("rst_count", 64'(count), 64'd0);
      check_val("rst_valid", 64'(inst_valid), 64'd0);
      check_val("rst_inst", 64'(|inst_out), 64'd0);
      check_val("rst_pc", 64'(|inst_pc_out), 64'd0);
      check_val("rst_ready", 64'(fetch_grp_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    fetch_grp_valid = '0;
    dec_ready       = 1'b0;
    rst             = 1'b0;
  endtask

  function automatic logic [WN-1:0] rand_mask();
    int lo, hi;
    if ($urandom_range(0, 7) == 0) return '0;
    lo = $urandom_range(0, WN - 1);
    hi = $urandom_range(lo, WN - 1);
    return WN'(((1 << (hi + 1)) - 1) & ~((1 << lo) - 1));
  endfunction

  initial begin
    reset_check(3);

`ifndef FETCH_BUF_BYPASS_EN
    // full block from empty, then drain three per cycle
    step(8'hFF, 32'h1000, 1'b1, 1'b0);
    check_val("d_pc0", 64'(inst_pc_out[31:0]), 64'h1000);
    check_val("d_pc1", 64'(inst_pc_out[63:32]), 64'h1004);
    check_val("d_pc2", 64'(inst_pc_out[95:64]), 64'h1008);
    check_val("d_valid", 64'(inst_valid), 64'h7);
    check_val("d_cnt8", 64'(count), 64'd8);
    step('0, '0, 1'b1, 1'b0);
    check_val("d_cnt5", 64'(count), 64'd5);
    step('0, '0, 1'b1, 1'b0);
    check_val("d_cnt2", 64'(count), 64'd2);
    check_val("d_valid2", 64'(inst_valid), 64'h3);
    step('0, '0, 1'b1, 1'b0);
    check_val("d_cnt0", 64'(count), 64'd0);

    // upper half of a block, PC pointing mid-block
    step(8'hF0, 32'h2010, 1'b0, 1'b0);
    check_val("h_cnt4", 64'(count), 64'd4);
    check_val("h_pc0", 64'(inst_pc_out[31:0]), 64'h2010);
    check_val("h_pc2", 64'(inst_pc_out[95:64]), 64'h2018);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);

    // ready drops once fewer than a block of entries are free
    step('0, '0, 1'b0, 1'b1);
    step(8'hFF, 32'h4000, 1'b0, 1'b0);
    step(8'h01, 32'h4020, 1'b0, 1'b0);
    check_val("f_cnt9", 64'(count), 64'd9);
    check_val("f_ready0", 64'(fetch_grp_ready), 64'd0);
    step('0, '0, 1'b1, 1'b0);
    check_val("f_cnt6", 64'(count), 64'd6);
    check_val("f_ready1", 64'(fetch_grp_ready), 64'd1);

    // walk head up to entry 15 and push across the wrap
    step('0, '0, 1'b0, 1'b1);
    step(8'hFF, 32'h6000, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step(8'hFF, 32'h6020, 1'b0, 1'b0);
    check_val("w_cnt10", 64'(count), 64'd10);
    check_val("w_ready0", 64'(fetch_grp_ready), 64'd0);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step(8'h01, 32'h6040, 1'b0, 1'b0);
    step(8'hFF, 32'h6060, 1'b1, 1'b0);
    check_val("w_cnt8", 64'(count), 64'd8);
    check_val("w_pc0", 64'(inst_pc_out[31:0]), 64'h6060);
    for (int i = 0; i < 3; i++) step('0, '0, 1'b1, 1'b0);

    // flush beats a simultaneous push and pop
    step(8'hFF, 32'h5000, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step(8'h03, 32'h5020, 1'b0, 1'b0);
    check_val("x_cnt7", 64'(count), 64'd7);
    step(8'hFF, 32'h5040, 1'b1, 1'b1);
    check_val("x_cnt0", 64'(count), 64'd0);
    check_val("x_valid0", 64'(inst_valid), 64'd0);
`else
    // bypass from empty: decode sees three words in the push cycle
    step(8'h0F, 32'h3000, 1'b1, 1'b0);
    check_val("b_cnt1", 64'(count), 64'd1);
    check_val("b_pc0", 64'(inst_pc_out[31:0]), 64'h300C);
    step('0, '0, 1'b1, 1'b0);
`endif

    for (int c = 0; c < 400; c++) begin
      if (c == 200) reset_check(2);
      step(rand_mask(), $urandom(), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
